nes_fb_writer: RTL and testbench

NES_FB_WRITER -- requirements
Module: nes_fb_writer

---
 rtl/nes_fb_pkg.sv | 24 ++
 rtl/nes_fb_lane_packer.sv | 79 +++++++
 rtl/nes_fb_writer.sv | 99 +++++++++
 tb/tb_nes_fb_writer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/nes_fb_pkg.sv
// rtl/nes_fb_pkg.sv - shared constants, FSM state type and word-address helper for the NES frame-buffer writer
package nes_fb_pkg;
  localparam int FB_WIDTH     = 256;
  localparam int FB_HEIGHT    = 240;
  localparam int PIX_PER_WORD = 8;

  localparam int COLOR_W     = 6;
  localparam int LANE_SEL_W  = 3;
  localparam int ROW_W       = 8;
  localparam int COL_WORD_W  = 5;
  localparam int WORD_ADDR_W = 1 + ROW_W + COL_WORD_W;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    CAPTURE  = 2'd1,
    DONE     = 2'd2
  } fb_wr_state_t;

  function automatic logic [WORD_ADDR_W-1:0] fb_word_addr(input logic bank,
                                                          input logic [ROW_W-1:0] row,
                                                          input logic [COL_WORD_W-1:0] col_word);
    return {bank, row, col_word};
  endfunction
endpackage

// File: rtl/nes_fb_lane_packer.sv
// rtl/nes_fb_lane_packer.sv - gathers eight pixels into one RAM word and issues registered word writes
module nes_fb_lane_packer
  import nes_fb_pkg::*;
#(
  parameter int ADDR_WIDTH = 18,
  parameter int LANE_WIDTH = 8,
  parameter int NB_LANES   = 9
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           accept,
  input  logic [WORD_ADDR_W-1:0]         word_addr,
  input  logic [LANE_SEL_W-1:0]          lane,
  input  logic [COLOR_W-1:0]             color,
  input  logic                           drain,
  output logic                           pend_valid,
  output logic                           gap,
  output logic [NB_LANES-1:0]            ram_we,
  output logic [ADDR_WIDTH-1:0]          ram_addr,
  output logic [NB_LANES*LANE_WIDTH-1:0] ram_di
);
  logic [PIX_PER_WORD-1:0]            mask, mask_n, flush_mask;
  logic [PIX_PER_WORD*LANE_WIDTH-1:0] data, data_n, flush_data;
  logic [WORD_ADDR_W-1:0]             pend_addr, addr_n, flush_addr;
  logic                               flush;

  always_comb begin
    pend_valid = |mask;
    gap        = accept && pend_valid && (word_addr != pend_addr);
    flush      = 1'b0;
    flush_mask = mask;
    flush_data = data;
    flush_addr = pend_addr;
    mask_n     = mask;
    data_n     = data;
    addr_n     = pend_addr;
    if (accept) begin
      // A discontinuity retires the old word while the new pixel opens a fresh one.
      if (gap || !pend_valid) begin
        flush  = gap;
        mask_n = '0;
        data_n = '0;
      end
      mask_n[lane] = 1'b1;
      data_n[lane*LANE_WIDTH +: LANE_WIDTH] = LANE_WIDTH'(color);
      addr_n = word_addr;
      if (!gap && lane == LANE_SEL_W'(PIX_PER_WORD-1)) begin
        flush      = 1'b1;
        flush_mask = mask_n;
        flush_data = data_n;
        flush_addr = word_addr;
        mask_n     = '0;
      end
    end else if (drain && pend_valid) begin
      flush  = 1'b1;
      mask_n = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask      <= '0;
      data      <= '0;
      pend_addr <= '0;
      ram_we    <= '0;
      ram_addr  <= '0;
      ram_di    <= '0;
    end else begin
      mask      <= mask_n;
      data      <= data_n;
      pend_addr <= addr_n;
      ram_we    <= flush ? NB_LANES'(flush_mask) : '0;
      if (flush) begin
        ram_addr <= ADDR_WIDTH'(flush_addr);
        ram_di   <= (NB_LANES*LANE_WIDTH)'(flush_data);
      end
    end
  end
endmodule

// File: rtl/nes_fb_writer.sv
// rtl/nes_fb_writer.sv - captures one visible NES frame into a word-wide frame-buffer RAM
// Optional double buffering via macro NES_FB_DOUBLE_BUFFER_EN.
module nes_fb_writer
  import nes_fb_pkg::*;
#(
  parameter int ADDR_WIDTH = 18,
  parameter int LANE_WIDTH = 8,
  parameter int NB_LANES   = 9
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           capture_en,
  input  logic                           pix_valid,
  input  logic [5:0]                     pix_color,
  input  logic [8:0]                     pix_scanline,
  input  logic [8:0]                     pix_cycle,
  output logic [NB_LANES-1:0]            ram_we,
  output logic [ADDR_WIDTH-1:0]          ram_addr,
  output logic [NB_LANES*LANE_WIDTH-1:0] ram_di,
  output logic                           frame_done,
  output logic                           front_bank,
  output logic [15:0]                    gap_count
);
  fb_wr_state_t state, state_n;
  logic visible, at_sof, at_last, accept, drain, pend_valid, gap;
  logic done_wait, done_now, bank;

  assign visible = pix_valid && (pix_scanline <= 9'(FB_HEIGHT-1)) && (pix_cycle <= 9'(FB_WIDTH-1));
  assign at_sof  = visible && (pix_scanline == 9'd0) && (pix_cycle == 9'd0);
  assign at_last = visible && (pix_scanline == 9'(FB_HEIGHT-1)) && (pix_cycle == 9'(FB_WIDTH-1));
  assign drain   = (state == DONE);
  // Last write is either the final pixel's flush or, if a partial word remains, the drain one cycle later.
  assign done_now = (drain && !pend_valid) || done_wait;

  always_comb begin
    state_n = state;
    accept  = 1'b0;
    case (state)
      WAIT_SOF: if (at_sof && capture_en) begin
        accept  = 1'b1;
        state_n = CAPTURE;
      end
      CAPTURE: if (visible) begin
        accept = 1'b1;
        if (at_last) state_n = DONE;
      end
      DONE:    state_n = WAIT_SOF;
      default: state_n = WAIT_SOF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= WAIT_SOF;
      done_wait  <= 1'b0;
      frame_done <= 1'b0;
      gap_count  <= '0;
    end else begin
      state      <= state_n;
      done_wait  <= drain && pend_valid;
      frame_done <= done_now;
      if (gap && gap_count != 16'hFFFF) gap_count <= gap_count + 16'd1;
    end
  end

`ifdef NES_FB_DOUBLE_BUFFER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank       <= 1'b0;
      front_bank <= 1'b0;
    end else if (done_now) begin
      bank       <= ~bank;
      front_bank <= bank;
    end
  end
`else
  assign bank       = 1'b0;
  assign front_bank = 1'b0;
`endif

  nes_fb_lane_packer #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .LANE_WIDTH(LANE_WIDTH),
    .NB_LANES  (NB_LANES)
  ) u_packer (
    .clk       (clk),
    .rst_n     (rst_n),
    .accept    (accept),
    .word_addr (fb_word_addr(bank, pix_scanline[7:0], pix_cycle[7:3])),
    .lane      (pix_cycle[2:0]),
    .color     (pix_color),
    .drain     (drain),
    .pend_valid(pend_valid),
    .gap       (gap),
    .ram_we    (ram_we),
    .ram_addr  (ram_addr),
    .ram_di    (ram_di)
  );
endmodule

// File: tb/tb_nes_fb_writer.sv
// tb/tb_nes_fb_writer.sv - directed self-checking bench for nes_fb_writer
module tb_nes_fb_writer;
  localparam int AW = 18;
  localparam int LW = 8;
  localparam int NL = 9;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          capture_en;
  logic          pix_valid;
  logic [5:0]    pix_color;
  logic [8:0]    pix_scanline;
  logic [8:0]    pix_cycle;
  logic [NL-1:0] ram_we;
  logic [AW-1:0] ram_addr;
  logic [NL*LW-1:0] ram_di;
  logic          frame_done;
  logic          front_bank;
  logic [15:0]   gap_count;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  nes_fb_writer #(.ADDR_WIDTH(AW), .LANE_WIDTH(LW), .NB_LANES(NL)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .capture_en  (capture_en),
    .pix_valid   (pix_valid),
    .pix_color   (pix_color),
    .pix_scanline(pix_scanline),
    .pix_cycle   (pix_cycle),
    .ram_we      (ram_we),
    .ram_addr    (ram_addr),
    .ram_di      (ram_di),
    .frame_done  (frame_done),
    .front_bank  (front_bank),
    .gap_count   (gap_count)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pix(input int s, input int c, input logic [5:0] col);
    pix_valid    = 1'b1;
    pix_scanline = 9'(s);
    pix_cycle    = 9'(c);
    pix_color    = col;
    step();
    pix_valid    = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; capture_en = 1'b0; pix_valid = 1'b0;
    pix_color = '0; pix_scanline = '0; pix_cycle = '0;
    step(); step();
    rst_n = 1'b1;
    step();
    tests++; if (ram_we !== 9'h000) begin fails++; $display("FAIL reset_we: got %h want 000", ram_we); end
    tests++; if (ram_addr !== 18'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", ram_addr); end
    tests++; if (ram_di !== 72'h0) begin fails++; $display("FAIL reset_di: got %h want 0", ram_di); end
    tests++; if ({frame_done, front_bank} !== 2'b00) begin fails++; $display("FAIL reset_flags: got %b want 00", {frame_done, front_bank}); end
    tests++; if (gap_count !== 16'h0) begin fails++; $display("FAIL reset_gap: got %h want 0", gap_count); end
  endtask

  task automatic test_no_sof();
    int seen = 0;
    capture_en = 1'b1;
    for (int c = 8; c < 24; c++) begin
      pix(3, c, 6'(c));
      if (ram_we !== 9'h0) seen++;
    end
    capture_en = 1'b0;
    for (int c = 0; c < 8; c++) begin
      pix(0, c, 6'(c));
      if (ram_we !== 9'h0) seen++;
    end
    tests++; if (seen != 0) begin fails++; $display("FAIL no_sof_writes: got %0d want 0", seen); end
  endtask

  task automatic test_gap();
    capture_en = 1'b1;
    for (int c = 0; c < 8; c++) pix(0, c, 6'(c + 1));
    tests++; if (ram_we !== 9'h0FF || ram_addr !== 18'h0) begin fails++; $display("FAIL sof_word: got we=%h addr=%h want we=0ff addr=0", ram_we, ram_addr); end
    tests++; if (ram_di !== 72'h00_0807060504030201) begin fails++; $display("FAIL sof_data: got %h want 000807060504030201", ram_di); end
    pix(5, 0, 6'h01); pix(5, 1, 6'h02); pix(5, 2, 6'h03); pix(5, 3, 6'h3F);
    tests++; if (ram_we !== 9'h000) begin fails++; $display("FAIL gap_nowrite: got %h want 000", ram_we); end
    pix(5, 16, 6'h10);
    tests++; if (ram_we !== 9'h00F || ram_addr !== 18'h0A0) begin fails++; $display("FAIL gap_flush: got we=%h addr=%h want we=00f addr=0a0", ram_we, ram_addr); end
    tests++; if (ram_di !== 72'h00_000000003F030201) begin fails++; $display("FAIL gap_data: got %h want 00000000003f030201", ram_di); end
    tests++; if (gap_count !== 16'd1) begin fails++; $display("FAIL gap_count: got %0d want 1", gap_count); end
    for (int c = 17; c < 24; c++) pix(5, c, 6'(c));
    tests++; if (ram_we !== 9'h0FF || ram_addr !== 18'h0A2) begin fails++; $display("FAIL gap_next: got we=%h addr=%h want we=0ff addr=0a2", ram_we, ram_addr); end
  endtask

  task automatic test_ignored();
    int seen = 0;
    pix(240, 0, 6'h05); if (ram_we !== 9'h0) seen++;
    pix(10, 300, 6'h06); if (ram_we !== 9'h0) seen++;
    pix(240, 7, 6'h07); if (ram_we !== 9'h0) seen++;
    pix_scanline = 9'd5; pix_cycle = 9'd31; step(); if (ram_we !== 9'h0) seen++;
    tests++; if (seen != 0) begin fails++; $display("FAIL ignored_writes: got %0d want 0", seen); end
    tests++; if (gap_count !== 16'd1) begin fails++; $display("FAIL ignored_gap: got %0d want 1", gap_count); end
  endtask

  task automatic test_reset_mid();
    pix(10, 5, 6'h2A);
    tests++; if (ram_we !== 9'h0) begin fails++; $display("FAIL mid_prewrite: got %h want 000", ram_we); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (ram_we !== 9'h0 || ram_addr !== 18'h0 || ram_di !== 72'h0) begin fails++; $display("FAIL mid_async_ram: got we=%h addr=%h di=%h want zeros", ram_we, ram_addr, ram_di); end
    tests++; if (gap_count !== 16'h0 || frame_done !== 1'b0 || front_bank !== 1'b0) begin fails++; $display("FAIL mid_async_flags: got gap=%h fd=%b fb=%b want zeros", gap_count, frame_done, front_bank); end
    step();
    rst_n = 1'b1;
    step();
    tests++; if (ram_we !== 9'h0) begin fails++; $display("FAIL mid_after_rst: got %h want 000", ram_we); end
    pix(10, 6, 6'h01); pix(10, 7, 6'h02);
    tests++; if (ram_we !== 9'h0) begin fails++; $display("FAIL mid_no_resume: got %h want 000", ram_we); end
  endtask

  task automatic test_full_frame();
    int writes = 0, bad = 0, fd = 0;
    capture_en = 1'b1;
    for (int s = 0; s < 240; s++) begin
      for (int c = 0; c < 256; c++) begin
        pix_valid = 1'b1; pix_scanline = 9'(s); pix_cycle = 9'(c); pix_color = 6'(c);
        step();
        if (ram_we !== 9'h0) begin
          if (ram_we !== 9'h0FF || ram_addr !== AW'(writes)) bad++;
          writes++;
        end
        if (frame_done !== 1'b0) fd++;
      end
    end
    pix_valid = 1'b0;
    tests++; if (writes != 7680) begin fails++; $display("FAIL full_writes: got %0d want 7680", writes); end
    tests++; if (bad != 0) begin fails++; $display("FAIL full_we_addr: got %0d bad writes want 0", bad); end
    tests++; if (fd != 0) begin fails++; $display("FAIL full_early_done: got %0d want 0", fd); end
    step();
    tests++; if (frame_done !== 1'b1 || front_bank !== 1'b0) begin fails++; $display("FAIL full_done: got fd=%b fb=%b want fd=1 fb=0", frame_done, front_bank); end
    step();
    tests++; if (frame_done !== 1'b0 || ram_we !== 9'h0) begin fails++; $display("FAIL full_done_pulse: got fd=%b we=%h want fd=0 we=000", frame_done, ram_we); end
  endtask

  task automatic test_second_frame();
    logic [AW-1:0] base;
    logic          exp_fb;
`ifdef NES_FB_DOUBLE_BUFFER_EN
    base = 18'h02000; exp_fb = 1'b1;
`else
    base = 18'h00000; exp_fb = 1'b0;
`endif
    for (int c = 0; c < 8; c++) pix(0, c, 6'(c));
    tests++; if (ram_we !== 9'h0FF || ram_addr !== base) begin fails++; $display("FAIL second_first: got we=%h addr=%h want we=0ff addr=%h", ram_we, ram_addr, base); end
    for (int c = 248; c < 256; c++) pix(239, c, 6'(c));
    tests++; if (ram_we !== 9'h0FF || ram_addr !== (base | 18'h01DFF)) begin fails++; $display("FAIL second_last: got we=%h addr=%h want we=0ff addr=%h", ram_we, ram_addr, base | 18'h01DFF); end
    tests++; if (gap_count !== 16'h0) begin fails++; $display("FAIL second_gap: got %0d want 0", gap_count); end
    step();
    tests++; if (frame_done !== 1'b1 || front_bank !== exp_fb) begin fails++; $display("FAIL second_done: got fd=%b fb=%b want fd=1 fb=%b", frame_done, front_bank, exp_fb); end
  endtask

  initial begin
    test_reset();
    test_no_sof();
    test_gap();
    test_ignored();
    test_reset_mid();
    test_full_frame();
    test_second_frame();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
